matrix_packetizer: RTL and testbench
====================================

MATRIX_PACKETIZER -- requirements
Module: matrix_packetizer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, meaning the element buffer depth (power of two, 4..64).
REQ-002 SHALL have parameter COORD_W, default 4, meaning the width of each destination coordinate (X and Y).
REQ-003 SHALL have port clk, input, 1 bit, meaning the single system clock.
REQ-004 SHALL have port resetn, input, 1 bit, meaning reset: synchronous to clk and active-low.
REQ-005 SHALL have ports in_matrix (in, 8), in_matrix_en (in, 1), in_matrix_end_row (in, 1) and in_matrix_end (in, 1), meaning the CPU matrix write strobes and data.
REQ-006 SHALL have ports in_position (in, 8) and in_position_en (in, 1), meaning the destination node write.
REQ-007 SHALL have port out_pkt, output, 2*COORD_W+25 bits, meaning a packet {dest_y, dest_x, row[7:0], col[7:0], last, data[7:0]}, MSB first.
REQ-008 SHALL have ports out_valid (out, 1) and out_ready (in, 1), meaning the injection handshake to the NoC router.
REQ-009 SHALL have ports overflow (out, 1) and busy (out, 1), meaning the sticky drop flag and the activity status.
REQ-010 SHALL have ports stat_sent (out, 16) and stat_dropped (out, 16), meaning the statistics counters (see Configuration).

Function
REQ-011 SHALL latch dest_x=in_position[COORD_W-1:0] and dest_y=in_position[2*COORD_W-1:COORD_W] on in_position_en; an element captured in the same cycle uses the old destination.
REQ-012 SHALL push {dest, row, col, last=0, in_matrix} into the FIFO on in_matrix_en, then increment col modulo 256.
REQ-013 SHALL, on in_matrix_end_row, increment row modulo 256 and clear col; when coincident with in_matrix_en, the element is pushed with the pre-update row/col.
REQ-014 SHALL, on in_matrix_end, enqueue an end marker {dest, row, col=0, last=1, data=0}, then clear row and col.
REQ-015 SHALL push at most one entry per cycle; if in_matrix_end coincides with in_matrix_en, the element goes first and the marker is pushed the next cycle via an END_PENDING state.
REQ-016 Input FSM SHALL have states IDLE (row=col=0, no element yet), IN_MATRIX (at least one element since the last end) and END_PENDING (marker deferred one cycle, then IDLE); in_matrix_end in IDLE still emits a marker.
REQ-017 SHALL drop any push attempted while the FIFO is full and set overflow; a deferred marker that finds the FIFO full is also dropped.
REQ-018 SHALL drive out_pkt/out_valid from registers; minimum latency from push to out_valid high is 1 cycle.
REQ-019 SHALL hold out_pkt stable while out_valid && !out_ready; a transfer occurs when out_valid && out_ready.
REQ-020 SHALL sustain one transfer per cycle while the FIFO is non-empty and out_ready stays high.
REQ-021 SHALL allow a push into a full FIFO to succeed when a pop occurs in the same cycle.
REQ-022 SHALL drive busy high when the FIFO is non-empty, out_valid is high or the state is END_PENDING.
REQ-023 SHALL preserve the order of packets as pushed.

Reset
REQ-024 SHALL, while resetn is low at a clk edge, clear the FIFO, row, col, destination, out_pkt, out_valid, overflow, busy and the statistics counters, and set the state to IDLE.
REQ-025 SHALL discard in-flight and buffered packets on reset mid-stream; out_valid is low in the first cycle after resetn rises.

Configuration
REQ-026 With macro MATRIX_PACKETIZER_STATS_EN defined, stat_sent SHALL count transfers and stat_dropped SHALL count dropped pushes, each 16-bit saturating at 0xFFFF.
REQ-027 Without MATRIX_PACKETIZER_STATS_EN, stat_sent and stat_dropped SHALL be constant 0 and no counter logic is built.

Verification
REQ-028 position 0x21, elements 0x0A,0x0B, end_row, 0x0C, end; out_ready=1 -> packets (x=1,y=2): (r0,c0,0x0A), (r0,c1,0x0B), (r1,c0,0x0C), then marker (r1,c0,last=1).
REQ-029 out_ready=0 for 10 cycles with 3 pushes -> out_pkt stable with the first packet; release -> 3 transfers on consecutive cycles.
REQ-030 17 pushes with out_ready=0 (FIFO_DEPTH=16) -> the 17th is dropped, overflow=1, stat_dropped=1 (STATS_EN), and overflow remains set after draining.
REQ-031 in_matrix_en and in_matrix_end in the same cycle -> element packet (last=0) followed by the marker (last=1); busy is high during END_PENDING.
REQ-032 256 elements without end_row -> col wraps 255->0 and row is unchanged.
REQ-033 resetn low mid-stream with 5 packets buffered -> out_valid=0, busy=0, overflow=0, and the next element emits with r0,c0.

Source files
------------

// File: rtl/matrix_packetizer.sv
// matrix_packetizer: turns CPU matrix writes into NoC packets
// {dest_y, dest_x, row, col, last, data}. Elements and end-of-matrix markers
// are queued in an element buffer and presented on a registered output stage.
// Optional feature: define MATRIX_PACKETIZER_STATS_EN to build the 16-bit
// saturating transfer/drop counters; otherwise stat_sent/stat_dropped are 0.
// Handshake: a packet moves when out_valid && out_ready on a rising clk edge;
// while out_valid is high and out_ready is low, out_pkt and out_valid hold.
// The buffer capacity is FIFO_DEPTH packets in total, counting the one held
// in the output register.
// COORD_W must not exceed 4, because both coordinates come from in_position.
module matrix_packetizer #(
    parameter int FIFO_DEPTH = 16,
    parameter int COORD_W    = 4
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [7:0]             in_matrix,
    input  logic                   in_matrix_en,
    input  logic                   in_matrix_end_row,
    input  logic                   in_matrix_end,
    input  logic [7:0]             in_position,
    input  logic                   in_position_en,
    output logic [2*COORD_W+24:0]  out_pkt,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   overflow,
    output logic                   busy,
    output logic [15:0]            stat_sent,
    output logic [15:0]            stat_dropped,
    output logic [1:0]             dbg_state
);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int PKT_W = 2 * COORD_W + 25;

    typedef enum logic [1:0] {
        S_IDLE        = 2'd0,
        S_IN_MATRIX   = 2'd1,
        S_END_PENDING = 2'd2
    } state_t;

    state_t                 state_q;
    logic [2*COORD_W-1:0]   dest_q;
    logic [7:0]             row_q;
    logic [7:0]             col_q;

    logic [PKT_W-1:0]       mem [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr_q;
    logic [AW-1:0]          rd_ptr_q;
    logic [AW:0]            fifo_cnt_q;
    logic [PKT_W-1:0]       out_pkt_q;
    logic                   out_valid_q;
    logic                   overflow_q;

    logic                   push_req;
    logic [PKT_W-1:0]       push_pkt;
    logic                   full;
    logic                   fifo_empty;
    logic                   transfer;
    logic                   load;
    logic                   push_ok;
    logic                   dropped;

    // Select at most one entry to push this cycle; a deferred marker wins.
    always_comb begin
        push_req = 1'b0;
        push_pkt = '0;
        if (state_q == S_END_PENDING) begin
            push_req = 1'b1;
            push_pkt = {dest_q, row_q, 8'h00, 1'b1, 8'h00};
        end else if (in_matrix_en) begin
            push_req = 1'b1;
            push_pkt = {dest_q, row_q, col_q, 1'b0, in_matrix};
        end else if (in_matrix_end) begin
            push_req = 1'b1;
            push_pkt = {dest_q, row_q, 8'h00, 1'b1, 8'h00};
        end
    end

    assign fifo_empty = (fifo_cnt_q == '0);
    assign full       = ((fifo_cnt_q + {{AW{1'b0}}, out_valid_q}) == (AW+1)'(FIFO_DEPTH));
    assign transfer   = out_valid_q && out_ready;
    assign load       = !fifo_empty && (!out_valid_q || out_ready);
    // A full buffer still accepts a push when the output drains this cycle.
    assign push_ok    = push_req && (!full || transfer);
    assign dropped    = push_req && !push_ok;

    // Input FSM with destination, row and column tracking. Matrix strobes
    // arriving during END_PENDING are ignored while the marker goes out.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            dest_q  <= '0;
            row_q   <= '0;
            col_q   <= '0;
        end else begin
            if (in_position_en) dest_q <= in_position[2*COORD_W-1:0];
            case (state_q)
                S_END_PENDING: begin
                    row_q   <= '0;
                    col_q   <= '0;
                    state_q <= S_IDLE;
                end
                default: begin
                    if (in_matrix_en)      col_q <= col_q + 8'd1;
                    if (in_matrix_end_row) begin
                        row_q <= row_q + 8'd1;
                        col_q <= '0;
                    end
                    if (in_matrix_end) begin
                        if (in_matrix_en) begin
                            state_q <= S_END_PENDING;
                        end else begin
                            row_q   <= '0;
                            col_q   <= '0;
                            state_q <= S_IDLE;
                        end
                    end else if (in_matrix_en) begin
                        state_q <= S_IN_MATRIX;
                    end
                end
            endcase
        end
    end

    // Buffer storage; contents are don't-care once the pointers are reset.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q] <= push_pkt;
    end

    // Buffer pointers, occupancy, output register and sticky overflow.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fifo_cnt_q  <= '0;
            out_pkt_q   <= '0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (load) begin
                rd_ptr_q  <= rd_ptr_q + 1'b1;
                out_pkt_q <= mem[rd_ptr_q];
            end
            case ({push_ok, load})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + 1'b1;
                2'b01:   fifo_cnt_q <= fifo_cnt_q - 1'b1;
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
            if (load)          out_valid_q <= 1'b1;
            else if (transfer) out_valid_q <= 1'b0;
            if (dropped) overflow_q <= 1'b1;
        end
    end

`ifdef MATRIX_PACKETIZER_STATS_EN
    logic [15:0] sent_q;
    logic [15:0] drop_q;

    // Saturating counters of completed transfers and dropped pushes.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            sent_q <= '0;
            drop_q <= '0;
        end else begin
            if (transfer && sent_q != 16'hFFFF) sent_q <= sent_q + 16'd1;
            if (dropped && drop_q != 16'hFFFF)  drop_q <= drop_q + 16'd1;
        end
    end

    assign stat_sent    = sent_q;
    assign stat_dropped = drop_q;
`else
    assign stat_sent    = 16'h0000;
    assign stat_dropped = 16'h0000;
`endif

    assign out_pkt   = out_pkt_q;
    assign out_valid = out_valid_q;
    assign overflow  = overflow_q;
    assign busy      = !fifo_empty || out_valid_q || (state_q == S_END_PENDING);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_matrix_packetizer.sv
// Testbench for matrix_packetizer: a table of single-cycle input records with
// the packet each one must produce and the FSM state after the edge, followed
// by hand-written stall, overflow, column-wrap and mid-stream reset sequences.
module tb_matrix_packetizer;
    localparam int PW = 33;

`ifdef MATRIX_PACKETIZER_STATS_EN
    localparam int STATS = 1;
`else
    localparam int STATS = 0;
`endif

    logic          clk;
    logic          resetn;
    logic [7:0]    in_matrix;
    logic          in_matrix_en;
    logic          in_matrix_end_row;
    logic          in_matrix_end;
    logic [7:0]    in_position;
    logic          in_position_en;
    logic [PW-1:0] out_pkt;
    logic          out_valid;
    logic          out_ready;
    logic          overflow;
    logic          busy;
    logic [15:0]   stat_sent;
    logic [15:0]   stat_dropped;
    logic [1:0]    dbg_state;

    matrix_packetizer dut (
        .clk               (clk),
        .resetn            (resetn),
        .in_matrix         (in_matrix),
        .in_matrix_en      (in_matrix_en),
        .in_matrix_end_row (in_matrix_end_row),
        .in_matrix_end     (in_matrix_end),
        .in_position       (in_position),
        .in_position_en    (in_position_en),
        .out_pkt           (out_pkt),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .overflow          (overflow),
        .busy              (busy),
        .stat_sent         (stat_sent),
        .stat_dropped      (stat_dropped),
        .dbg_state         (dbg_state)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [PW-1:0] exp_q[$];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end, got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    // Comparison helper
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [PW-1:0] mk(input int y, input int x, input int r,
                                         input int c, input int l, input int d);
        logic [3:0] yy, xx;
        logic [7:0] rr, cc, dd;
        yy = y[3:0]; xx = x[3:0]; rr = r[7:0]; cc = c[7:0]; dd = d[7:0];
        return {yy, xx, rr, cc, (l != 0), dd};
    endfunction

    // Scoreboard: every transfer must match the oldest expected packet
    always @(negedge clk) begin
        if (resetn && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pkt: got 0x%0h required no transfer", out_pkt);
            end else begin
                chk("pkt", 64'(out_pkt), 64'(exp_q.pop_front()));
            end
        end
    end

    // Driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pos(input logic [7:0] p);
        in_position    = p;
        in_position_en = 1'b1;
        step();
        in_position_en = 1'b0;
    endtask

    task automatic push(input logic [7:0] d, input logic acc, input logic [PW-1:0] e);
        in_matrix    = d;
        in_matrix_en = 1'b1;
        if (acc) exp_q.push_back(e);
        step();
        in_matrix_en = 1'b0;
    endtask

    task automatic drain(input int maxc);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < maxc) begin
            step();
            n++;
        end
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        exp_q.delete();
        step();
        step();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_out_pkt", 64'(out_pkt), 64'd0);
        chk("rst_state", 64'(dbg_state), 64'd0);
        chk("rst_stat_sent", 64'(stat_sent), 64'd0);
        chk("rst_stat_dropped", 64'(stat_dropped), 64'd0);
        resetn = 1'b1;
        step();
        chk("post_rst_out_valid", 64'(out_valid), 64'd0);
    endtask

    typedef struct {
        logic          pos_en;
        logic [7:0]    pos;
        logic          en;
        logic          er;
        logic          ed;
        logic [7:0]    data;
        logic          has_exp;
        logic [PW-1:0] exp_pkt;
        logic [1:0]    exp_state;
    } vec_t;

    function automatic vec_t v(input int pe, input int p, input int en, input int er,
                               input int ed, input int d, input int he,
                               input logic [PW-1:0] e, input int s);
        vec_t r;
        r.pos_en    = (pe != 0);
        r.pos       = 8'(p);
        r.en        = (en != 0);
        r.er        = (er != 0);
        r.ed        = (ed != 0);
        r.data      = 8'(d);
        r.has_exp   = (he != 0);
        r.exp_pkt   = e;
        r.exp_state = 2'(s);
        return r;
    endfunction

    vec_t vecs[12];

    initial begin
        resetn            = 1'b0;
        in_matrix         = '0;
        in_matrix_en      = 1'b0;
        in_matrix_end_row = 1'b0;
        in_matrix_end     = 1'b0;
        in_position       = '0;
        in_position_en    = 1'b0;
        out_ready         = 1'b1;

        // Basic stream, end in IDLE, destination change, coincident end
        vecs[0]  = v(1, 'h21, 0, 0, 0, 0,     0, '0, 0);
        vecs[1]  = v(0, 0,    1, 0, 0, 'h0A,  1, mk(2, 1, 0, 0, 0, 'h0A), 1);
        vecs[2]  = v(0, 0,    1, 0, 0, 'h0B,  1, mk(2, 1, 0, 1, 0, 'h0B), 1);
        vecs[3]  = v(0, 0,    0, 1, 0, 0,     0, '0, 1);
        vecs[4]  = v(0, 0,    1, 0, 0, 'h0C,  1, mk(2, 1, 1, 0, 0, 'h0C), 1);
        vecs[5]  = v(0, 0,    0, 0, 1, 0,     1, mk(2, 1, 1, 0, 1, 0), 0);
        vecs[6]  = v(0, 0,    0, 0, 1, 0,     1, mk(2, 1, 0, 0, 1, 0), 0);
        vecs[7]  = v(1, 'h35, 1, 0, 0, 'h11,  1, mk(2, 1, 0, 0, 0, 'h11), 1);
        vecs[8]  = v(0, 0,    1, 0, 0, 'h12,  1, mk(3, 5, 0, 1, 0, 'h12), 1);
        vecs[9]  = v(0, 0,    1, 1, 0, 'h13,  1, mk(3, 5, 0, 2, 0, 'h13), 1);
        vecs[10] = v(0, 0,    1, 0, 1, 'h14,  1, mk(3, 5, 1, 0, 0, 'h14), 2);
        vecs[11] = v(0, 0,    0, 0, 0, 0,     1, mk(3, 5, 1, 0, 1, 0), 0);

        do_reset();

        for (int i = 0; i < 12; i++) begin
            in_position_en    = vecs[i].pos_en;
            in_position       = vecs[i].pos;
            in_matrix_en      = vecs[i].en;
            in_matrix_end_row = vecs[i].er;
            in_matrix_end     = vecs[i].ed;
            in_matrix         = vecs[i].data;
            if (vecs[i].has_exp) exp_q.push_back(vecs[i].exp_pkt);
            step();
            in_position_en    = 1'b0;
            in_matrix_en      = 1'b0;
            in_matrix_end_row = 1'b0;
            in_matrix_end     = 1'b0;
            chk("vec_state", 64'(dbg_state), 64'(vecs[i].exp_state));
            if (vecs[i].exp_state == 2'd2) chk("end_pending_busy", 64'(busy), 64'd1);
        end
        drain(10);

        // Stall: output holds the first packet, then three back-to-back transfers
        do_reset();
        out_ready = 1'b0;
        set_pos(8'h21);
        push(8'hA0, 1'b1, mk(2, 1, 0, 0, 0, 'hA0));
        push(8'hA1, 1'b1, mk(2, 1, 0, 1, 0, 'hA1));
        push(8'hA2, 1'b1, mk(2, 1, 0, 2, 0, 'hA2));
        repeat (10) begin
            @(negedge clk);
            chk("stall_valid", 64'(out_valid), 64'd1);
            chk("stall_pkt", 64'(out_pkt), 64'(mk(2, 1, 0, 0, 0, 'hA0)));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("burst_valid", 64'(out_valid), 64'd1);
        end
        @(negedge clk);
        chk("burst_done_valid", 64'(out_valid), 64'd0);
        chk("burst_empty", 64'(exp_q.size()), 64'd0);
        step();

        // Overflow: 16 fit, the 17th is dropped; full buffer accepts a push
        // in the same cycle as a transfer
        do_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 17; k++) begin
            push(8'(k), (k < 16), mk(0, 0, 0, k, 0, k));
            if (k == 15) chk("no_overflow_at_16", 64'(overflow), 64'd0);
        end
        chk("overflow_set", 64'(overflow), 64'd1);
        chk("stat_dropped_1", 64'(stat_dropped), 64'(STATS));
        out_ready = 1'b1;
        push(8'h77, 1'b1, mk(0, 0, 0, 17, 0, 'h77));
        drain(40);
        chk("overflow_sticky", 64'(overflow), 64'd1);
        chk("stat_dropped_after", 64'(stat_dropped), 64'(STATS));
        chk("stat_sent_17", 64'(stat_sent), 64'(STATS * 17));

        // Column wraps 255 -> 0 without touching the row
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 256; k++) push(8'(k), 1'b1, mk(0, 0, 0, k, 0, k));
        push(8'hEE, 1'b1, mk(0, 0, 0, 0, 0, 'hEE));
        drain(10);
        chk("wrap_no_overflow", 64'(overflow), 64'd0);

        // Reset with five packets buffered; stream restarts at row 0, col 0
        do_reset();
        out_ready = 1'b0;
        set_pos(8'h12);
        for (int k = 0; k < 5; k++) push(8'(8'h40 + k), 1'b1, mk(1, 2, 0, k, 0, 8'h40 + k));
        chk("pre_reset_busy", 64'(busy), 64'd1);
        do_reset();
        out_ready = 1'b1;
        push(8'h5A, 1'b1, mk(0, 0, 0, 0, 0, 'h5A));
        drain(10);
        step();
        chk("final_idle_busy", 64'(busy), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
